// File: rtl/inst_fetch_unit_pkg.sv
// Shared ISA constants and fetch-path types used by the fetch unit and its queue.
package inst_fetch_unit_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] HALT_WORD = 32'h0000_0000;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_AND    = 4'h2;
  localparam logic [3:0] OP_OR     = 4'h3;
  localparam logic [3:0] OP_XOR    = 4'h4;
  localparam logic [3:0] OP_LOAD   = 4'h5;
  localparam logic [3:0] OP_STORE  = 4'h6;
  localparam logic [3:0] OP_BRANCH = 4'h7;
  localparam logic [3:0] OP_MUL    = 4'h8;
  localparam logic [3:0] OP_MAC4   = 4'h9;

  localparam int OPC_HI = 31, OPC_LO = 28;
  localparam int RD_HI  = 27, RD_LO  = 24;
  localparam int RS1_HI = 23, RS1_LO = 20;
  localparam int RS2_HI = 19, RS2_LO = 16;
  localparam int IMM_HI = 15, IMM_LO = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'd3;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory, redirect and decode-handshake signals of the fetch unit.
interface inst_fetch_unit_if;

  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        halted;

  modport master (
    output imem_pc,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready,
    output halted
  );

  modport slave (
    input  imem_pc,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready,
    input  halted
  );

endinterface

// File: rtl/inst_fetch_unit_queue.sv
// Shift-style synchronous FIFO of {pc, instr}; entry 0 is always the head.
module fetch_queue
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  fetch_entry_t  i_din,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  fetch_entry_t  r_mem [DEPTH];
  logic [CW-1:0] r_count;

  fetch_entry_t  w_mem_nxt [DEPTH];
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_wr_idx;
  logic          w_pop;
  logic          w_push;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CW'(DEPTH));
  assign w_pop    = i_pop && !o_empty;
  assign w_push   = i_push && (!o_full || w_pop);
  // The write slot sits just past the survivors of this cycle's shift.
  assign w_wr_idx = r_count - CW'(w_pop);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) w_mem_nxt[i] = r_mem[i];
    if (w_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) w_mem_nxt[i] = r_mem[i + 1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (w_push && (CW'(i) == w_wr_idx)) w_mem_nxt[i] = i_din;
    end
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= w_mem_nxt[i];
    end
  end

  assign o_head  = r_mem[0];
  assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch PC owner and RUN/HALT control; feeds fetched words into fetch_queue for decode.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          QUEUE_DEPTH  = 2,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  inst_fetch_unit_if.master bus
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_pc_nxt;

  logic          w_pop;
  logic          w_push;
  logic          w_flush;
  logic          w_push_ok;
  logic          w_halt_word;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_din;

  assign w_pop       = !w_empty && bus.out_ready;
  assign w_push_ok   = (r_state == ST_RUN) && (!w_full || w_pop);
  assign w_halt_word = HALT_ON_ZERO && (bus.imem_instr == HALT_WORD);
  assign w_din       = '{pc: r_fetch_pc, instr: bus.imem_instr};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_fetch_pc;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    if (bus.redirect_valid) begin
      w_flush     = 1'b1;
      w_pc_nxt    = align_pc(bus.redirect_pc);
      w_state_nxt = ST_RUN;
    end else if (w_push_ok) begin
      if (w_halt_word) begin
        w_state_nxt = ST_HALT;
      end else begin
        w_push   = 1'b1;
        w_pc_nxt = r_fetch_pc + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_pc_nxt;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .CW    (CW)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (w_din),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.imem_pc   = r_fetch_pc;
  assign bus.out_valid = !w_empty;
  assign bus.out_pc    = w_head.pc;
  assign bus.out_instr = w_head.instr;
  assign bus.halted    = (r_state == ST_HALT) && (w_count == '0);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: expected instruction streams per fetch start, checked on each accept.
module tb_inst_fetch_unit;

  logic clk;
  logic rst_n;

  inst_fetch_unit_if bus();

  inst_fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rom [64];

  assign bus.imem_instr = (bus.imem_pc < 32'h100) ? rom[bus.imem_pc[7:2]] :
                          ((bus.imem_pc == 32'hFFFF_FFFC) ? 32'hA5A5_0001 : 32'h0);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_halt_pc;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [31:0] rom_rd(input logic [31:0] a);
    if (a < 32'h100) return rom[a[7:2]];
    if (a == 32'hFFFF_FFFC) return 32'hA5A5_0001;
    return 32'h0;
  endfunction

  // Everything from an aligned start address up to the first zero word is delivered in order.
  function automatic void sb_load(input logic [31:0] start);
    logic [31:0] p;
    logic [31:0] w;
    exp_t        e;
    sb.delete();
    p = start & ~32'd3;
    for (int k = 0; k < 200; k++) begin
      w = rom_rd(p);
      if (w == 32'h0) break;
      e.pc    = p;
      e.instr = w;
      sb.push_back(e);
      p = p + 32'd4;
    end
    m_halt_pc = p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(posedge clk) begin
    if (!rst_n) sb_load(32'h0);
    else if (bus.redirect_valid) sb_load(bus.redirect_pc);
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL extra_output: got pc %h instr %h, expected no output", bus.out_pc, bus.out_instr);
      end else begin
        e = sb.pop_front();
        chk("out_pc", bus.out_pc, e.pc);
        chk("out_instr", bus.out_instr, e.instr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_halt(input string tag);
    int k;
    k = 0;
    while (!bus.halted && k < 300) begin
      tick();
      k++;
    end
    chk({tag, "_halted"}, 32'(bus.halted), 32'd1);
    chk({tag, "_halt_pc"}, bus.imem_pc, m_halt_pc);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    rom[0] = 32'h5100_0201; rom[1] = 32'h6110_0403; rom[2] = 32'h5200_0605;
    rom[3] = 32'h6220_0807; rom[4] = 32'h8312_0000; rom[5] = 32'h0430_0000;
    rom[6] = 32'h4512_0000; rom[7] = 32'h0000_0000;
    for (int i = 8; i < 64; i++) begin
      w = $urandom;
      if (w == 32'h0) w = 32'h1;
      if ($urandom_range(0, 7) == 0) w = 32'h0;
      rom[i] = w;
    end
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_imem_pc", bus.imem_pc, 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_instr", bus.out_instr, 32'h0);

    // Straight-line program run at full throughput.
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("first_out_pc", bus.out_pc, 32'h0);
    for (int i = 0; i < 7; i++) begin
      chk("tput_valid", 32'(bus.out_valid), 32'd1);
      tick();
    end
    chk("t1_halted", 32'(bus.halted), 32'd1);
    chk("t1_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_imem_pc", bus.imem_pc, 32'h1C);

    // Back-pressure fills the queue and freezes the PC.
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("stall_imem_pc", bus.imem_pc, 32'h08);
    chk("stall_valid", 32'(bus.out_valid), 32'd1);
    chk("stall_head_pc", bus.out_pc, 32'h0);
    chk("stall_head_instr", bus.out_instr, 32'h5100_0201);
    bus.out_ready = 1'b1;
    wait_halt("t2");

    // Reset with a full queue.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_imem_pc", bus.imem_pc, 32'h0);
    chk("t6_halted", 32'(bus.halted), 32'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    wait_halt("t6");

    // Redirect while 0x04 is at the head.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("t3_head_pc", bus.out_pc, 32'h04);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h10;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t3_flushed", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t3_lat_valid", 32'(bus.out_valid), 32'd1);
    chk("t3_lat_pc", bus.out_pc, 32'h10);
    wait_halt("t3");

    // Redirect out of HALT.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h14;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t4_unhalt", 32'(bus.halted), 32'd0);
    wait_halt("t4");

    // Unaligned redirect target.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h13;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t5_imem_pc", bus.imem_pc, 32'h10);
    tick();
    chk("t5_out_pc", bus.out_pc, 32'h10);
    wait_halt("t5");

    // PC wraps past the top of the address space.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFE;
    tick();
    bus.redirect_valid = 1'b0;
    chk("wrap_imem_pc", bus.imem_pc, 32'hFFFF_FFFC);
    wait_halt("wrap");

    for (int c = 0; c < 3000; c++) begin
      rst_n         = ($urandom_range(0, 299) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 5))
        0:       bus.redirect_pc = 32'hFFFF_FFFC;
        1:       bus.redirect_pc = 32'h18;
        default: bus.redirect_pc = 32'($urandom_range(0, 32'h120));
      endcase
      tick();
    end
    rst_n              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    wait_halt("rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
